// File: rtl/dcache_refill_unit_pkg.sv
// Shared sizing, state encoding and address helper for the dCache refill path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_refill_unit_pkg;

   localparam int ADDR_W     = 32;
   localparam int BLOCK_BITS = 1024;
   localparam int MEM_DATA_W = 64;
   localparam int BEATS      = BLOCK_BITS / MEM_DATA_W;
   localparam int OFF_BITS   = 7;
   localparam int CNT_W      = $clog2(BEATS);
   localparam int MASK_W     = BLOCK_BITS / 8;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      COLLECT,
      FILL,
      DONE
   } refill_state_t;

   // Clear the in-block offset so every fetch and fill addresses a whole block.
   function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_refill_unit_line_buffer.sv
// Assembles one cache block from memory response beats, tracking the beat index.
// Latency: a beat lands in block_dat the cycle after beat_vld.
// Backpressure: none; every beat_vld beat is consumed.
module refill_line_buffer
   import dcache_refill_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  beat_vld,
   input  logic [MEM_DATA_W-1:0] beat_dat,
   output logic [CNT_W-1:0]      beat_cnt,
   output logic                  final_beat,
   output logic [BLOCK_BITS-1:0] block_dat
);

   logic cnt_at_end;

   assign cnt_at_end = (beat_cnt == CNT_W'(BEATS - 1));
   assign final_beat = beat_vld && cnt_at_end;

   // Beat counter: advances per accepted beat and wraps so the next block starts at beat 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
      end else if (beat_vld) begin
         beat_cnt <= cnt_at_end ? '0 : beat_cnt + 1'b1;
      end
   end

   // Block register: each beat overwrites its own slice; contents persist between refills.
   always_ff @(posedge clk) begin
      if (rst) begin
         block_dat <= '0;
      end else if (beat_vld) begin
         block_dat[beat_cnt*MEM_DATA_W +: MEM_DATA_W] <= beat_dat;
      end
   end

endmodule

// File: rtl/dcache_refill_unit.sv
// Services dCache read/write misses: fetches the block from memory and writes it into the dCache.
// Latency: accept@T, request@T+1, beats T+2..T+17, sent_repair@T+18, repair_resolved@T+19 (best case).
// Backpressure: request waits on mem_req_ready; response beats are never stalled; misses must stall while busy.
module dcache_refill_unit
   import dcache_refill_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_miss,
   input  logic [ADDR_W-1:0]     rd_miss_addr,
   input  logic                  wr_miss,
   input  logic [ADDR_W-1:0]     wr_miss_addr,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_req_addr,
   input  logic                  mem_resp_valid,
   input  logic [MEM_DATA_W-1:0] mem_resp_data,
   input  logic                  mem_resp_last,
   output logic                  sent_repair,
   output logic [ADDR_W-1:0]     fill_addr,
   output logic [BLOCK_BITS-1:0] fill_data,
   output logic [MASK_W-1:0]     fill_mask,
   output logic                  repair_resolved,
   output logic                  busy,
   output logic                  proto_err
);

   refill_state_t     state;
   refill_state_t     state_nxt;
   logic [ADDR_W-1:0] cur_addr;
   logic              accept;
   logic [ADDR_W-1:0] accept_addr;
   logic              pend_vld;
   logic [ADDR_W-1:0] pend_addr;
   logic              pend_load;
   logic [ADDR_W-1:0] pend_load_addr;
   logic              pend_take;
   logic              miss_dropped;
   logic              collect_beat;
   logic [CNT_W-1:0]  beat_cnt;
   logic              final_beat;
   logic              last_expected;

   // Beats only count while collecting; anything arriving in other states is stray.
   assign collect_beat  = (state == COLLECT) && mem_resp_valid;
   assign last_expected = (beat_cnt == CNT_W'(BEATS - 1));

   refill_line_buffer u_line_buffer (
      .clk        (clk),
      .rst        (rst),
      .beat_vld   (collect_beat),
      .beat_dat   (mem_resp_data),
      .beat_cnt   (beat_cnt),
      .final_beat (final_beat),
      .block_dat  (fill_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, miss arbitration (read > pending write > new write) and pending-slot control.
   always_comb begin
      state_nxt      = state;
      accept         = 1'b0;
      accept_addr    = '0;
      pend_load      = 1'b0;
      pend_load_addr = '0;
      pend_take      = 1'b0;
      miss_dropped   = 1'b0;

      case (state)
         IDLE: begin
            if (rd_miss) begin
               accept      = 1'b1;
               accept_addr = block_align(rd_miss_addr);
               if (wr_miss) begin
                  if (!pend_vld) begin
                     pend_load      = 1'b1;
                     pend_load_addr = block_align(wr_miss_addr);
                  end else begin
                     miss_dropped = 1'b1;
                  end
               end
            end else if (pend_vld) begin
               accept      = 1'b1;
               accept_addr = pend_addr;
               pend_take   = 1'b1;
               // The slot frees this cycle, so a concurrent write miss can take it.
               if (wr_miss) begin
                  pend_load      = 1'b1;
                  pend_load_addr = block_align(wr_miss_addr);
               end
            end else if (wr_miss) begin
               accept      = 1'b1;
               accept_addr = block_align(wr_miss_addr);
            end
            if (accept) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (final_beat) begin
               state_nxt = FILL;
            end
         end
         FILL: begin
            state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // While a refill is in flight only one write miss can be parked.
      if (state != IDLE) begin
         if (rd_miss) begin
            miss_dropped = 1'b1;
         end
         if (wr_miss) begin
            if (!pend_vld) begin
               pend_load      = 1'b1;
               pend_load_addr = block_align(wr_miss_addr);
            end else begin
               miss_dropped = 1'b1;
            end
         end
      end
   end

   // Current refill address, captured at acceptance and held through FILL.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr <= '0;
      end else if (accept) begin
         cur_addr <= accept_addr;
      end
   end

   // Single-entry pending write-miss slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld  <= 1'b0;
         pend_addr <= '0;
      end else if (pend_load) begin
         pend_vld  <= 1'b1;
         pend_addr <= pend_load_addr;
      end else if (pend_take) begin
         pend_vld  <= 1'b0;
      end
   end

   // Sticky protocol error: the beat counter decides where the block ends, mem_resp_last must agree.
   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err <= 1'b0;
      end else if (collect_beat && (mem_resp_last != last_expected)) begin
         proto_err <= 1'b1;
      end
   end

   // Outputs decode directly from state so they are all zero in IDLE and out of reset.
   always_comb begin
      mem_req_valid   = (state == REQ);
      mem_req_addr    = (state == REQ) ? cur_addr : '0;
      sent_repair     = (state == FILL);
      fill_mask       = (state == FILL) ? {MASK_W{1'b1}} : '0;
      repair_resolved = (state == DONE);
      busy            = (state != IDLE) || pend_vld;
      fill_addr       = cur_addr;
   end

   // The controller stalls while busy, so losing a miss here means it broke that contract.
   a_no_miss_dropped: assert property (@(posedge clk) disable iff (rst) !miss_dropped);

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed bench for dcache_refill_unit with hand-computed expectations.
// Latency: checks exact refill timing against the acceptance cycle.
// Backpressure: exercises a stalled memory request handshake.
module tb_dcache_refill_unit;
   import dcache_refill_unit_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  rd_miss;
   logic [ADDR_W-1:0]     rd_miss_addr;
   logic                  wr_miss;
   logic [ADDR_W-1:0]     wr_miss_addr;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [ADDR_W-1:0]     mem_req_addr;
   logic                  mem_resp_valid;
   logic [MEM_DATA_W-1:0] mem_resp_data;
   logic                  mem_resp_last;
   logic                  sent_repair;
   logic [ADDR_W-1:0]     fill_addr;
   logic [BLOCK_BITS-1:0] fill_data;
   logic [MASK_W-1:0]     fill_mask;
   logic                  repair_resolved;
   logic                  busy;
   logic                  proto_err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   dcache_refill_unit dut (
      .clk             (clk),
      .rst             (rst),
      .rd_miss         (rd_miss),
      .rd_miss_addr    (rd_miss_addr),
      .wr_miss         (wr_miss),
      .wr_miss_addr    (wr_miss_addr),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_req_addr    (mem_req_addr),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_data   (mem_resp_data),
      .mem_resp_last   (mem_resp_last),
      .sent_repair     (sent_repair),
      .fill_addr       (fill_addr),
      .fill_data       (fill_data),
      .fill_mask       (fill_mask),
      .repair_resolved (repair_resolved),
      .busy            (busy),
      .proto_err       (proto_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a miss for one cycle; returns the cycle number in which it was presented.
   task automatic issue(input logic rd, input logic [ADDR_W-1:0] rda,
                        input logic wr, input logic [ADDR_W-1:0] wra, output int t0);
      rd_miss      = rd;
      rd_miss_addr = rda;
      wr_miss      = wr;
      wr_miss_addr = wra;
      t0           = cyc;
      step();
      rd_miss = 1'b0;
      wr_miss = 1'b0;
   endtask

   // Drive beats first..first+n-1 with data base+k; gap idle cycles between beats.
   task automatic send_beats(input int base, input int first, input int n, input int gap,
                             input int last_idx, output bit saw_fill);
      saw_fill = 1'b0;
      for (int k = first; k < first + n; k++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 64'(base + k);
         mem_resp_last  = (k == last_idx);
         @(negedge clk);
         if (sent_repair) saw_fill = 1'b1;
         step();
         mem_resp_valid = 1'b0;
         mem_resp_last  = 1'b0;
         if (k != first + n - 1) begin
            repeat (gap) begin
               @(negedge clk);
               if (sent_repair) saw_fill = 1'b1;
               step();
            end
         end
      end
   endtask

   // Called in the cycle after the final beat: checks the fill write and the resolve pulse.
   task automatic finish_fill(input string tag, input logic [ADDR_W-1:0] exp_addr,
                              input int base, input int t0, input bit chk_time);
      @(negedge clk);
      check_eq({tag, "_sent_repair"}, 128'(sent_repair), 128'(1));
      check_eq({tag, "_fill_mask"}, 128'(fill_mask), {128{1'b1}});
      check_eq({tag, "_fill_addr"}, 128'(fill_addr), 128'(exp_addr));
      check_eq({tag, "_resolved_early"}, 128'(repair_resolved), 128'(0));
      for (int k = 0; k < BEATS; k++) begin
         check_eq($sformatf("%s_data%0d", tag, k), 128'(fill_data[k*MEM_DATA_W +: MEM_DATA_W]),
                  128'(64'(base + k)));
      end
      if (chk_time) check_eq({tag, "_fill_cycle"}, 128'(cyc - t0), 128'(18));
      step();
      @(negedge clk);
      check_eq({tag, "_resolved"}, 128'(repair_resolved), 128'(1));
      check_eq({tag, "_sent_after"}, 128'(sent_repair), 128'(0));
      check_eq({tag, "_mask_after"}, 128'(fill_mask), 128'(0));
      if (chk_time) check_eq({tag, "_resolve_cycle"}, 128'(cyc - t0), 128'(19));
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int stable;
      bit saw_fill;
      bit early;

      rst            = 1'b1;
      rd_miss        = 1'b0;
      rd_miss_addr   = '0;
      wr_miss        = 1'b0;
      wr_miss_addr   = '0;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_last  = 1'b0;

      // Reset state
      repeat (2) step();
      @(negedge clk);
      check_eq("rst_req_valid", 128'(mem_req_valid), 128'(0));
      check_eq("rst_req_addr", 128'(mem_req_addr), 128'(0));
      check_eq("rst_sent", 128'(sent_repair), 128'(0));
      check_eq("rst_resolved", 128'(repair_resolved), 128'(0));
      check_eq("rst_busy", 128'(busy), 128'(0));
      check_eq("rst_proto_err", 128'(proto_err), 128'(0));
      check_eq("rst_fill_mask", 128'(fill_mask), 128'(0));
      check_eq("rst_fill_data_any", 128'(|fill_data), 128'(0));
      step();
      rst = 1'b0;
      step();

      // Read miss, ready immediately, back-to-back beats data=k
      issue(1'b1, 32'h0000_1234, 1'b0, 32'h0, t0);
      @(negedge clk);
      check_eq("t1_req_valid", 128'(mem_req_valid), 128'(1));
      check_eq("t1_req_addr", 128'(mem_req_addr), 128'(32'h0000_1200));
      check_eq("t1_busy", 128'(busy), 128'(1));
      step();
      send_beats(0, 0, BEATS, 0, BEATS - 1, saw_fill);
      check_eq("t1_no_early_fill", 128'(saw_fill), 128'(0));
      finish_fill("t1", 32'h0000_1200, 0, t0, 1'b1);
      @(negedge clk);
      check_eq("t1_idle_busy", 128'(busy), 128'(0));
      check_eq("t1_proto_err", 128'(proto_err), 128'(0));
      step();

      // Request stalled for 5 cycles
      mem_req_ready = 1'b0;
      issue(1'b0, 32'h0, 1'b1, 32'h0000_4455, t0);
      stable = 0;
      early  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_req_valid && (mem_req_addr == 32'h0000_4400)) stable++;
         if (sent_repair) early = 1'b1;
         if (i == 5) mem_req_ready = 1'b1;
         step();
      end
      check_eq("t2_req_stable_cycles", 128'(stable), 128'(6));
      check_eq("t2_no_fill_before_hs", 128'(early), 128'(0));
      send_beats(32'h100, 0, BEATS, 0, BEATS - 1, saw_fill);
      finish_fill("t2", 32'h0000_4400, 32'h100, 0, 1'b0);

      // Simultaneous read and write miss: write is parked, then serviced without re-request
      issue(1'b1, 32'h0000_0100, 1'b1, 32'h0000_2080, t0);
      @(negedge clk);
      check_eq("t3_first_addr", 128'(mem_req_addr), 128'(32'h0000_0100));
      step();
      send_beats(32'h200, 0, BEATS, 0, BEATS - 1, saw_fill);
      finish_fill("t3a", 32'h0000_0100, 32'h200, 0, 1'b0);
      @(negedge clk);
      check_eq("t3_pend_busy", 128'(busy), 128'(1));
      check_eq("t3_idle_req", 128'(mem_req_valid), 128'(0));
      step();
      @(negedge clk);
      check_eq("t3_second_valid", 128'(mem_req_valid), 128'(1));
      check_eq("t3_second_addr", 128'(mem_req_addr), 128'(32'h0000_2080));
      step();
      send_beats(32'h300, 0, BEATS, 0, BEATS - 1, saw_fill);
      finish_fill("t3b", 32'h0000_2080, 32'h300, 0, 1'b0);
      @(negedge clk);
      check_eq("t3_done_busy", 128'(busy), 128'(0));
      step();

      // Gapped beats with a premature last marker
      issue(1'b0, 32'h0, 1'b1, 32'h0000_3000, t0);
      @(negedge clk);
      check_eq("t4_proto_err_before", 128'(proto_err), 128'(0));
      step();
      send_beats(32'h400, 0, BEATS, 3, 10, saw_fill);
      check_eq("t4_no_early_fill", 128'(saw_fill), 128'(0));
      finish_fill("t4", 32'h0000_3000, 32'h400, 0, 1'b0);
      @(negedge clk);
      check_eq("t4_proto_err", 128'(proto_err), 128'(1));
      step();

      // Reset at beat 7, stray beats afterwards, then a clean refill
      issue(1'b1, 32'h0000_5000, 1'b0, 32'h0, t0);
      step();
      send_beats(32'h500, 0, 7, 0, 99, saw_fill);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'(32'h500 + 7);
      rst            = 1'b1;
      step();
      rst            = 1'b0;
      mem_resp_valid = 1'b0;
      @(negedge clk);
      check_eq("t5_rst_req_valid", 128'(mem_req_valid), 128'(0));
      check_eq("t5_rst_req_addr", 128'(mem_req_addr), 128'(0));
      check_eq("t5_rst_sent", 128'(sent_repair), 128'(0));
      check_eq("t5_rst_resolved", 128'(repair_resolved), 128'(0));
      check_eq("t5_rst_busy", 128'(busy), 128'(0));
      check_eq("t5_rst_proto_err", 128'(proto_err), 128'(0));
      check_eq("t5_rst_fill_addr", 128'(fill_addr), 128'(0));
      check_eq("t5_rst_fill_mask", 128'(fill_mask), 128'(0));
      check_eq("t5_rst_fill_data_any", 128'(|fill_data), 128'(0));
      step();
      send_beats(32'h500, 8, 8, 0, 15, saw_fill);
      check_eq("t5_stray_no_fill", 128'(saw_fill), 128'(0));
      @(negedge clk);
      check_eq("t5_stray_busy", 128'(busy), 128'(0));
      check_eq("t5_stray_data_any", 128'(|fill_data), 128'(0));
      check_eq("t5_stray_proto_err", 128'(proto_err), 128'(0));
      step();
      issue(1'b1, 32'h0000_7040, 1'b0, 32'h0, t0);
      @(negedge clk);
      check_eq("t5_new_addr", 128'(mem_req_addr), 128'(32'h0000_7000));
      step();
      send_beats(32'h900, 0, BEATS, 0, BEATS - 1, saw_fill);
      finish_fill("t5", 32'h0000_7000, 32'h900, t0, 1'b1);
      @(negedge clk);
      check_eq("t5_final_proto_err", 128'(proto_err), 128'(0));
      check_eq("t5_final_busy", 128'(busy), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
